counter_sequencer: RTL
======================

# counter_sequencer

Command-side initiator for the counter bank. It accepts a command over a valid/ready handshake and turns it into the bank's start/select/stopcount stimulus. It then waits for the selected counter's status bit, captures the bank's count output, and returns a response over a second valid/ready handshake. A fixed cycle limit bounds the wait. The block sits between a host/test controller and the counter bank top, and owns the bank's input side.

## Interface
- SUB_NUMBER, 2, number of counters in the bank; legal select values are 1..SUB_NUMBER.
- TIMEOUT, 1024, maximum cycles spent in WAIT before a timeout response; range 1..2^32-1.

- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_select  input  32  counter number, 1-based.
- cmd_stopcount  input  32  stop value forwarded to the bank.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer takes the response.
- rsp_data  output  32  captured count.
- rsp_timeout  output  1  response ended by timeout.
- rsp_error  output  1  command had an illegal select.
- ctr_start  output  1  start pulse to the bank.
- ctr_select  output  32  select driven to the bank.
- ctr_stopcount  output  32  stop value driven to the bank.
- ctr_status  input  SUB_NUMBER  bank status vector; bit k belongs to counter k+1.
- ctr_count  input  32  bank count output for the currently driven select.
- busy  output  1  high in every state except IDLE.

## Operation
- **States:** IDLE, ARM, WAIT, RESP. All outputs are registered.
- **Reset value:** every output is 0 and the state is IDLE. cmd_ready rises on the first edge after reset deasserts.
- **IDLE:**
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch cmd_select into ctr_select and cmd_stopcount into ctr_stopcount.
  - If 1<=cmd_select<=SUB_NUMBER, go to ARM.
  - Otherwise go to RESP with rsp_error=1, rsp_data=0 and rsp_timeout=0. ctr_select and ctr_stopcount are still driven with the latched values, and ctr_start stays 0.
  - cmd_ready drops on the accept edge.
- **ARM:**
  - ctr_start=1 for exactly one cycle, then go to WAIT.
  - Clear the wait counter.
- **WAIT:**
  - ctr_start=0.
  - Each cycle, test ctr_status[ctr_select-1].
  - If it is 1: rsp_data<=ctr_count, rsp_timeout<=0, go to RESP.
  - Otherwise increment the wait counter (32-bit, saturating; it never wraps).
  - When the counter reaches TIMEOUT-1 with status still 0: rsp_data<=ctr_count, rsp_timeout<=1, go to RESP.
  - If status and the timeout condition occur in the same cycle, status wins and rsp_timeout=0.
- **RESP:**
  - rsp_valid=1. rsp_data, rsp_timeout and rsp_error are held stable while rsp_valid&!rsp_ready.
  - On rsp_valid&rsp_ready: clear rsp_valid, rsp_error and rsp_timeout; return ctr_select and ctr_stopcount to 0; go to IDLE.
  - rsp_data holds its last value.
- ctr_select is held constant from the accept edge until the response handshake. The bank's count mux must stay on the selected counter during capture.
- Commands presented while cmd_ready=0 are ignored; the upstream holds them under the valid/ready rules.
- **Reset mid-operation:** asynchronous return to IDLE. All outputs go to 0 immediately, so ctr_start is cut and a pending response is discarded.

## Timing
- Accept edge at cycle T.
- ctr_start is high during cycle T+1 only.
- WAIT begins at T+2.
- If status is first high in cycle S (S>=T+2), rsp_valid is high from S+1. The capture is the ctr_count value in cycle S.
- **Timeout case:** rsp_valid at T+2+TIMEOUT.
- **Illegal select:** rsp_valid at T+1. ctr_start is never asserted.
- **Handshake:** with rsp_ready held 1, rsp_valid lasts one cycle and cmd_ready returns the following cycle. Minimum command-to-command spacing is 4 cycles for a status that is immediately high.
- Status already high at WAIT entry, from a previous run, completes in one WAIT cycle. Clearing it is the bank's responsibility.

## Test plan
- **Normal capture:** select=1, stopcount=10. Model asserts status[0] 12 cycles after start with ctr_count=10 → exactly one ctr_start pulse at T+1, and rsp_valid with rsp_data=10, rsp_timeout=0, rsp_error=0.
- **Second counter:** select=2, stopcount=5. Status[1] is asserted at WAIT entry and status[0] toggles → only bit 1 is honoured, ctr_select=2 throughout, and rsp_valid at T+3.
- **Timeout:** TIMEOUT=8, select=1, status held 0, ctr_count=7 → rsp_valid at T+10 with rsp_timeout=1 and rsp_data=7.
- **Illegal select:** cmd_select=0, then 3 (SUB_NUMBER=2) → rsp_error=1, rsp_data=0, rsp_valid at T+1, and no ctr_start pulse.
- **Backpressure:** rsp_ready low for 5 cycles → rsp_valid, rsp_data and ctr_select stay stable, cmd_ready stays 0, and a cmd_valid held high meanwhile is accepted only after the response handshake.
- **Reset mid-WAIT:** assert reset during WAIT → all outputs 0 asynchronously. After release, cmd_ready=1 on the first edge and a new command completes normally.

Source files
------------

// File: rtl/counter_sequencer.sv
// counter_sequencer: command-side initiator for the counter bank.
// Accepts a (select, stopcount) command, pulses the bank's start, waits for the
// selected counter's status bit (bounded by TIMEOUT cycles), captures the bank
// count and returns it as a response.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; a producer holding valid keeps its payload stable until that edge, and
// ready/valid driven by this block depend only on registered state.
module counter_sequencer #(
  parameter int unsigned SUB_NUMBER = 2,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [31:0]           cmd_select,
  input  logic [31:0]           cmd_stopcount,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_data,
  output logic                  rsp_timeout,
  output logic                  rsp_error,
  output logic                  ctr_start,
  output logic [31:0]           ctr_select,
  output logic [31:0]           ctr_stopcount,
  input  logic [SUB_NUMBER-1:0] ctr_status,
  input  logic [31:0]           ctr_count,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam int          SUB_N        = int'(SUB_NUMBER);
  localparam logic [31:0] SUB_MAX      = 32'(SUB_NUMBER);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

  state_t      state_q;
  logic        cmd_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_data_q;
  logic        rsp_timeout_q;
  logic        rsp_error_q;
  logic        ctr_start_q;
  logic [31:0] ctr_select_q;
  logic [31:0] ctr_stopcount_q;
  logic        busy_q;
  logic [31:0] wait_cnt_q;
  logic [31:0] wait_cnt_d;
  logic        sel_legal;
  logic        status_hit;

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign rsp_error     = rsp_error_q;
  assign ctr_start     = ctr_start_q;
  assign ctr_select    = ctr_select_q;
  assign ctr_stopcount = ctr_stopcount_q;
  assign busy          = busy_q;
  assign dbg_state     = state_q;

  // Select is 1-based; 0 and anything above the bank size are rejected.
  always_comb begin
    sel_legal = (cmd_select != 32'd0) && (cmd_select <= SUB_MAX);
  end

  // Status bit of the counter currently driven on ctr_select (bit k = counter k+1).
  always_comb begin
    status_hit = 1'b0;
    for (int k = 0; k < SUB_N; k++) begin
      if (ctr_select_q == 32'(k + 1)) begin
        status_hit = ctr_status[k];
      end
    end
  end

  // Saturating increment so a huge TIMEOUT can never be skipped by wrap-around.
  always_comb begin
    wait_cnt_d = (wait_cnt_q == 32'hFFFF_FFFF) ? wait_cnt_q : wait_cnt_q + 32'd1;
  end

  // Sequencer FSM; every output is a register written here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      cmd_ready_q     <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_data_q      <= 32'd0;
      rsp_timeout_q   <= 1'b0;
      rsp_error_q     <= 1'b0;
      ctr_start_q     <= 1'b0;
      ctr_select_q    <= 32'd0;
      ctr_stopcount_q <= 32'd0;
      busy_q          <= 1'b0;
      wait_cnt_q      <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q     <= 1'b0;
            busy_q          <= 1'b1;
            ctr_select_q    <= cmd_select;
            ctr_stopcount_q <= cmd_stopcount;
            if (sel_legal) begin
              ctr_start_q <= 1'b1;
              state_q     <= S_ARM;
            end else begin
              // Illegal select: answer straight away, never start the bank.
              rsp_valid_q   <= 1'b1;
              rsp_error_q   <= 1'b1;
              rsp_timeout_q <= 1'b0;
              rsp_data_q    <= 32'd0;
              state_q       <= S_RESP;
            end
          end
        end
        S_ARM: begin
          ctr_start_q <= 1'b0;
          wait_cnt_q  <= 32'd0;
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          // Status has priority over an expiring wait in the same cycle.
          if (status_hit) begin
            rsp_data_q    <= ctr_count;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state_q       <= S_RESP;
          end else if (wait_cnt_q == TIMEOUT_LAST) begin
            rsp_data_q    <= ctr_count;
            rsp_timeout_q <= 1'b1;
            rsp_valid_q   <= 1'b1;
            state_q       <= S_RESP;
          end else begin
            wait_cnt_q <= wait_cnt_d;
          end
        end
        S_RESP: begin
          // rsp_data keeps its value after the handshake; flags are cleared.
          if (rsp_ready) begin
            rsp_valid_q     <= 1'b0;
            rsp_error_q     <= 1'b0;
            rsp_timeout_q   <= 1'b0;
            ctr_select_q    <= 32'd0;
            ctr_stopcount_q <= 32'd0;
            busy_q          <= 1'b0;
            cmd_ready_q     <= 1'b1;
            state_q         <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
